modexp_arbiter: RTL and testbench

Round-robin scheduler that shares one modular-exponentiation engine (the `x^y mod m` FSM built on the Montgomery datapath) between `NUM_REQ` requesters, such as signature generation and challenge verification. It captures the granted requester's operands and issues a single `start` pulse. It waits for the engine's `ready`, then returns the result to that requester. It also owns the engine's reset and uses it to recover from a hung operation via a watchdog.

---
 rtl/modexp_pkg.sv | 22 ++
 rtl/modexp_arbiter_rr_pick.sv | 41 ++++
 rtl/modexp_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_modexp_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation scheduler.
//   state_t        : scheduler FSM states
//   Y_SIZE_W       : width of the exponent bit-count field
//   DEF_KEY_LENGTH : default operand / modulus width
//   DEF_E_WIDTH    : default extra exponent bits
//   WDOG_W         : watchdog counter width (TIMEOUT_CYCLES must fit below 2^WDOG_W)
package modexp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DRAIN,
        ST_RECOVER
    } state_t;

    localparam int Y_SIZE_W       = 10;
    localparam int DEF_KEY_LENGTH = 512;
    localparam int DEF_E_WIDTH    = 3;
    localparam int WDOG_W         = 24;

endpackage

// File: rtl/modexp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req   [N-1:0]     : request vector
//   ptr   [IDX_W-1:0] : last granted index; scanning starts at ptr+1
//   valid             : at least one request is set
//   idx   [IDX_W-1:0] : first set request found scanning ptr+1, ptr+2, ... mod N
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [IDX_W:0] shift;
    logic [IDX_W:0] pos;

    // Doubling the request vector turns the modulo rotation into a plain
    // shift: rot[j] is the request at position (ptr+1+j) mod N.
    always_comb begin
        shift = {1'b0, ptr} + (IDX_W + 1)'(1);
        req2  = {req, req};
        rot   = N'(req2 >> shift);
        valid = |rot;
        pos   = '0;
        // Walk downwards so the lowest rotated position is the one kept.
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pos = shift + (IDX_W + 1)'(j);
            end
        end
        // pos never exceeds 2N-1, so one conditional subtract wraps it.
        idx = (pos >= N_W) ? IDX_W'(pos - N_W) : IDX_W'(pos);
    end

endmodule

// File: rtl/modexp_arbiter.sv
// modexp_arbiter: round-robin scheduler sharing one x^y mod m engine.
//   clk, rst (sync, active-low)
//   req/req_x/req_y/req_y_size/req_m : per-requester request level and packed operands
//   ack, done (one-hot pulses), err, res : handshake and result back to requesters
//   busy                                 : scheduler not idle
//   eng_x/eng_m/eng_y/eng_y_size/eng_start, eng_ready/eng_out : engine side
//   eng_rst                              : engine reset (active-low), also pulsed by the watchdog
module modexp_arbiter
    import modexp_pkg::*;
#(
    parameter int KEY_LENGTH     = DEF_KEY_LENGTH,
    parameter int E_WIDTH        = DEF_E_WIDTH,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [NUM_REQ*KEY_LENGTH-1:0]           req_x,
    input  logic [NUM_REQ*(KEY_LENGTH+E_WIDTH)-1:0] req_y,
    input  logic [NUM_REQ*Y_SIZE_W-1:0]             req_y_size,
    input  logic [NUM_REQ*KEY_LENGTH-1:0]           req_m,
    output logic [NUM_REQ-1:0]                      ack,
    output logic [NUM_REQ-1:0]                      done,
    output logic                                    err,
    output logic [KEY_LENGTH-1:0]                   res,
    output logic                                    busy,
    output logic [KEY_LENGTH-1:0]                   eng_x,
    output logic [KEY_LENGTH-1:0]                   eng_m,
    output logic [KEY_LENGTH+E_WIDTH-1:0]           eng_y,
    output logic [Y_SIZE_W-1:0]                     eng_y_size,
    output logic                                    eng_start,
    input  logic                                    eng_ready,
    input  logic [KEY_LENGTH-1:0]                   eng_out,
    output logic                                    eng_rst
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int Y_W   = KEY_LENGTH + E_WIDTH;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    // Unpacked views of the per-requester operand slices.
    logic [KEY_LENGTH-1:0] x_arr    [NUM_REQ];
    logic [KEY_LENGTH-1:0] m_arr    [NUM_REQ];
    logic [Y_W-1:0]        y_arr    [NUM_REQ];
    logic [Y_SIZE_W-1:0]   ysz_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign x_arr[gi]   = req_x[gi*KEY_LENGTH +: KEY_LENGTH];
        assign m_arr[gi]   = req_m[gi*KEY_LENGTH +: KEY_LENGTH];
        assign y_arr[gi]   = req_y[gi*Y_W +: Y_W];
        assign ysz_arr[gi] = req_y_size[gi*Y_SIZE_W +: Y_SIZE_W];
    end

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  rcnt_q, rcnt_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  err_q, err_d;
    logic [KEY_LENGTH-1:0] res_q, res_d;
    logic                  eng_start_q, eng_start_d;
    logic [KEY_LENGTH-1:0] eng_x_q, eng_x_d;
    logic [KEY_LENGTH-1:0] eng_m_q, eng_m_d;
    logic [Y_W-1:0]        eng_y_q, eng_y_d;
    logic [Y_SIZE_W-1:0]   eng_y_size_q, eng_y_size_d;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        wdog_d       = wdog_q;
        rcnt_d       = rcnt_q;
        ack_d        = '0;
        done_d       = '0;
        err_d        = err_q;
        res_d        = res_q;
        eng_start_d  = 1'b0;
        eng_x_d      = eng_x_q;
        eng_m_d      = eng_m_q;
        eng_y_d      = eng_y_q;
        eng_y_size_d = eng_y_size_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    eng_x_d      = x_arr[pick_idx];
                    eng_m_d      = m_arr[pick_idx];
                    eng_y_d      = y_arr[pick_idx];
                    eng_y_size_d = ysz_arr[pick_idx];
                    gnt_d        = pick_idx;
                    ptr_d        = pick_idx;
                    ack_d        = NUM_REQ'(1) << pick_idx;
                    wdog_d       = '0;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                eng_start_d = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                // A ready seen on the last watchdog cycle still counts as success.
                if (eng_ready) begin
                    res_d   = eng_out;
                    err_d   = 1'b0;
                    done_d  = NUM_REQ'(1) << gnt_q;
                    state_d = ST_DRAIN;
                end else if (wdog_q == WDOG_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    done_d  = NUM_REQ'(1) << gnt_q;
                    rcnt_d  = 1'b0;
                    state_d = ST_RECOVER;
                end
            end
            ST_DRAIN: begin
                // Let a lingering ready fall so it cannot complete the next job.
                if (!eng_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                // Two cycles of engine reset: rcnt 0 then 1.
                if (rcnt_q) begin
                    state_d = ST_IDLE;
                end else begin
                    rcnt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            wdog_q       <= '0;
            rcnt_q       <= 1'b0;
            ack_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            res_q        <= '0;
            eng_start_q  <= 1'b0;
            eng_x_q      <= '0;
            eng_m_q      <= '0;
            eng_y_q      <= '0;
            eng_y_size_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            wdog_q       <= wdog_d;
            rcnt_q       <= rcnt_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
            res_q        <= res_d;
            eng_start_q  <= eng_start_d;
            eng_x_q      <= eng_x_d;
            eng_m_q      <= eng_m_d;
            eng_y_q      <= eng_y_d;
            eng_y_size_q <= eng_y_size_d;
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign err        = err_q;
    assign res        = res_q;
    assign busy       = (state_q != ST_IDLE);
    assign eng_x      = eng_x_q;
    assign eng_m      = eng_m_q;
    assign eng_y      = eng_y_q;
    assign eng_y_size = eng_y_size_q;
    assign eng_start  = eng_start_q;
    // Engine reset follows the system reset immediately, plus the recovery window.
    assign eng_rst    = rst & (state_q != ST_RECOVER);

endmodule

// File: tb/tb_modexp_arbiter.sv
// Bench for modexp_arbiter: behavioural engine, cycle-level job model and
// directed scenarios (contention, single job, stale ready, timeout,
// reset mid-wait, ready on the final watchdog cycle).
module tb_modexp_arbiter;

    localparam int KL = 16;
    localparam int EW = 3;
    localparam int NR = 2;
    localparam int TO = 16;
    localparam int YW = KL + EW;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*KL-1:0] req_x = '0;
    logic [NR*YW-1:0] req_y = '0;
    logic [NR*10-1:0] req_y_size = '0;
    logic [NR*KL-1:0] req_m = '0;
    logic [NR-1:0]    ack, done;
    logic             err, busy, eng_start, eng_rst;
    logic [KL-1:0]    res, eng_x, eng_m;
    logic [YW-1:0]    eng_y;
    logic [9:0]       eng_y_size;
    logic             eng_ready = 1'b0;
    logic [KL-1:0]    eng_out = '0;

    modexp_arbiter #(
        .KEY_LENGTH     (KL),
        .E_WIDTH        (EW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_y_size (req_y_size),
        .req_m      (req_m),
        .ack        (ack),
        .done       (done),
        .err        (err),
        .res        (res),
        .busy       (busy),
        .eng_x      (eng_x),
        .eng_m      (eng_m),
        .eng_y      (eng_y),
        .eng_y_size (eng_y_size),
        .eng_start  (eng_start),
        .eng_ready  (eng_ready),
        .eng_out    (eng_out),
        .eng_rst    (eng_rst)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic longint unsigned modpow(input longint unsigned x, input longint unsigned y,
                                               input int ysz, input longint unsigned m);
        longint unsigned r;
        if (m == 0) return 0;
        r = 1 % m;
        for (int i = ysz - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (y[i]) r = (r * x) % m;
        end
        return r;
    endfunction

    // Behavioural engine: ready rises e_lat cycles after start, stays e_hold cycles.
    int e_lat = 3, e_hold = 1, e_cnt = 0, e_left = 0;
    always @(posedge clk) begin
        #2;
        if (!eng_rst) begin
            e_cnt = 0; e_left = 0; eng_ready = 1'b0;
        end else begin
            if (e_cnt > 0) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    eng_out   = KL'(modpow(eng_x, eng_y, int'(eng_y_size), eng_m));
                    eng_ready = 1'b1;
                    e_left    = e_hold;
                end
            end else if (eng_ready) begin
                e_left--;
                if (e_left == 0) eng_ready = 1'b0;
            end
            if (eng_start) e_cnt = e_lat;
        end
    end

    // Job-level model: flags/counters describing where the current job is.
    bit            started = 0;
    bit            m_idle = 1, m_start_due = 0, m_wait = 0, m_drain = 0;
    int            m_rec = 0, m_wn = 0, m_ptr = NR - 1;
    logic [NR-1:0] exp_ack = '0, exp_done = '0;
    logic          exp_start = 0, m_err = 0;
    logic [KL-1:0] m_x = '0, m_m = '0, m_res = '0;
    logic [YW-1:0] m_y = '0;
    logic [9:0]    m_ysz = '0;

    int grant_log[$];
    int res_log[$];
    int last_done_cyc = 0, last_start_cyc = 0, ack_gap = 0;
    int cnt_done = 0, cnt_start_rdy = 0, cnt_rstlow = 0;

    always @(negedge clk) begin
        int g;
        cyc++;
        if (started) begin
            chk("ack", ack, exp_ack);
            chk("done", done, exp_done);
            chk("eng_start", eng_start, exp_start);
            chk("busy", busy, !m_idle);
            chk("eng_rst", eng_rst, rst && (m_rec == 0));
            chk("eng_x", eng_x, m_x);
            chk("eng_m", eng_m, m_m);
            chk("eng_y", eng_y, m_y);
            chk("eng_y_size", eng_y_size, m_ysz);
            chk("res", res, m_res);
            if (exp_done != 0) chk("err", err, m_err);

            if (ack != 0) begin
                for (int i = 0; i < NR; i++) if (ack[i]) grant_log.push_back(i);
                ack_gap = cyc - last_done_cyc;
            end
            if (done != 0) begin
                cnt_done++;
                last_done_cyc = cyc;
                if (!err) res_log.push_back(int'(res));
                $display("[TB] done=%b err=%0d res=%0h cycle=%0d", done, err, res, cyc);
            end
            if (eng_start) begin
                last_start_cyc = cyc;
                if (eng_ready) cnt_start_rdy++;
            end
            if (rst && !eng_rst) cnt_rstlow++;
        end

        // Advance the model to the next cycle using what the DUT sampled.
        exp_ack = '0; exp_done = '0; exp_start = 0;
        if (!rst) begin
            started = 1;
            m_idle = 1; m_start_due = 0; m_wait = 0; m_drain = 0; m_rec = 0;
            m_ptr = NR - 1; m_x = '0; m_m = '0; m_y = '0; m_ysz = '0;
            m_res = '0; m_err = 0;
        end else if (m_idle) begin
            g = -1;
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && req[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
            if (g >= 0) begin
                m_ptr = g;
                exp_ack = NR'(1) << g;
                m_x   = req_x[g*KL +: KL];
                m_m   = req_m[g*KL +: KL];
                m_y   = req_y[g*YW +: YW];
                m_ysz = req_y_size[g*10 +: 10];
                m_idle = 0; m_start_due = 1;
            end
        end else if (m_start_due) begin
            exp_start = 1; m_start_due = 0; m_wait = 1; m_wn = 0;
        end else if (m_wait) begin
            if (eng_ready) begin
                exp_done = NR'(1) << m_ptr; m_res = eng_out; m_err = 0;
                m_wait = 0; m_drain = 1;
            end else if (m_wn == TO - 1) begin
                exp_done = NR'(1) << m_ptr; m_res = '0; m_err = 1;
                m_wait = 0; m_rec = 2;
            end else begin
                m_wn++;
            end
        end else if (m_drain) begin
            if (!eng_ready) begin m_drain = 0; m_idle = 1; end
        end else if (m_rec > 0) begin
            m_rec--;
            if (m_rec == 0) m_idle = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ack != 0) seen = 1;
        end
        #1;
        if (!seen) timeout_fail(name);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done != 0) seen = 1;
        end
        #1;
        if (!seen) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (busy == 0) seen = 1;
        end
        #1;
        if (!seen) timeout_fail(name);
    endtask

    initial begin
        // Requester 0: 3^5 mod 7 = 5. Requester 1: 2^10 mod 11 = 1.
        req_x[0 +: KL] = 16'd3;  req_y[0 +: YW] = 19'd5;  req_y_size[0 +: 10] = 10'd3; req_m[0 +: KL] = 16'd7;
        req_x[KL +: KL] = 16'd2; req_y[YW +: YW] = 19'd10; req_y_size[10 +: 10] = 10'd4; req_m[KL +: KL] = 16'd11;
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk); #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_ack", ack, 2'b00);
        chk("reset_eng_x", eng_x, 16'd0);
        chk("reset_eng_rst", eng_rst, 1'b1);

        // Contention: both held high, grants must alternate starting at 0.
        grant_log.delete(); res_log.delete();
        step(); req = 2'b11;
        for (int i = 0; i < 400 && grant_log.size() < 4; i++) begin @(negedge clk); #1; end
        if (grant_log.size() < 4) timeout_fail("contention_grants");
        step(); req = 2'b00;
        wait_done("contention_last_done");
        wait_idle("contention_idle");
        if (grant_log.size() >= 4) begin
            chk("rr_grant0", grant_log[0], 0); chk("rr_grant1", grant_log[1], 1);
            chk("rr_grant2", grant_log[2], 0); chk("rr_grant3", grant_log[3], 1);
        end
        if (res_log.size() >= 4) begin
            chk("rr_res0", res_log[0], 5); chk("rr_res1", res_log[1], 1);
            chk("rr_res2", res_log[2], 5); chk("rr_res3", res_log[3], 1);
        end

        // Single requester latency.
        step(); req = 2'b01;
        @(negedge clk); chk("single_ack_t0", ack, 2'b00);
        @(negedge clk); chk("single_ack_t1", ack, 2'b01);
        @(negedge clk); chk("single_start_t2", eng_start, 1'b1);
        step(); req = 2'b00;
        wait_done("single_done");
        chk("single_done_vec", done, 2'b01);
        chk("single_res", res, 16'd5);
        chk("single_err", err, 1'b0);
        chk("single_latency", last_done_cyc - last_start_cyc, 4);
        wait_idle("single_idle");

        // Stale ready held 4 cycles; requester keeps asking.
        e_hold = 4; cnt_done = 0; cnt_start_rdy = 0;
        step(); req = 2'b01;
        wait_ack("stale_ack1");
        wait_done("stale_done1");
        wait_ack("stale_ack2");
        chk("stale_ack_gap", ack_gap, 5);
        step(); req = 2'b00;
        wait_done("stale_done2");
        wait_idle("stale_idle");
        repeat (6) step();
        chk("stale_done_count", cnt_done, 2);
        chk("stale_start_on_ready", cnt_start_rdy, 0);
        e_hold = 1;

        // Timeout: engine never answers.
        e_lat = 1000; cnt_rstlow = 0;
        step(); req = 2'b10;
        wait_ack("to_ack");
        step(); req = 2'b00;
        wait_done("to_done");
        chk("to_done_vec", done, 2'b10);
        chk("to_err", err, 1'b1);
        chk("to_res", res, 16'd0);
        chk("to_latency", last_done_cyc - last_start_cyc, 16);
        wait_idle("to_idle");
        chk("to_rst_cycles", cnt_rstlow, 2);

        // Reset in the middle of WAIT.
        step(); req = 2'b01;
        wait_ack("rw_ack");
        step(); req = 2'b00;
        repeat (3) step();
        cnt_done = 0;
        rst = 1'b0;
        @(negedge clk); chk("rw_eng_rst_low", eng_rst, 1'b0);
        step(); rst = 1'b1; e_lat = 3;
        @(negedge clk);
        chk("rw_busy", busy, 1'b0);
        chk("rw_eng_x", eng_x, 16'd0);
        chk("rw_done", done, 2'b00);
        step(); req = 2'b11;
        wait_ack("rw_ack2");
        if (grant_log.size() > 0) chk("rw_next_grant", grant_log[$], 0);
        step(); req = 2'b00;
        wait_done("rw_done2");
        wait_idle("rw_idle");
        chk("rw_done_count", cnt_done, 1);

        // Ready rises exactly on the final watchdog cycle.
        e_lat = 15; cnt_rstlow = 0;
        step(); req = 2'b01;
        wait_ack("co_ack");
        step(); req = 2'b00;
        wait_done("co_done");
        chk("co_err", err, 1'b0);
        chk("co_res", res, 16'd5);
        chk("co_latency", last_done_cyc - last_start_cyc, 16);
        wait_idle("co_idle");
        chk("co_no_recover", cnt_rstlow, 0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
